// File: rtl/starfield_pkg.sv
// Shared constants, state type and hash/level helpers for the parallax starfield.
package starfield_pkg;

    localparam logic [15:0] HASH_X    = 16'h9E37;
    localparam logic [15:0] HASH_Y    = 16'h7F4B;
    localparam logic [15:0] HASH_L    = 16'h1D3B;
    localparam int          MAX_LEVEL = 15;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Per-layer placement hash; every product is truncated to 16 bits.
    function automatic logic [15:0] star_hash(
        input logic [15:0] hx,
        input logic [15:0] y,
        input logic [3:0]  layer
    );
        logic [15:0] layer_num;
        layer_num = {12'd0, layer} + 16'd1;
        return (hx * HASH_X) ^ (y * HASH_Y) ^ (HASH_L * layer_num);
    endfunction

    function automatic logic [3:0] layer_level(
        input int layer,
        input int base,
        input int step
    );
        int lvl;
        lvl = base + layer * step;
        if (lvl > MAX_LEVEL) lvl = MAX_LEVEL;
        if (lvl < 0) lvl = 0;
        return 4'(lvl);
    endfunction

endpackage

// File: rtl/starfield_layer.sv
// One parallax layer: scroll offset, stage-1 scrolled column, and the
// stage-2 hash/threshold/level logic.
module starfield_layer
    import starfield_pkg::*;
#(
    parameter int         WIDTH      = 640,
    parameter int         XW         = 10,
    parameter int         YW         = 9,
    parameter int         LAYER      = 0,
    parameter logic [8:0] DENSITY    = 9'd6,
    parameter int         BASE_LEVEL = 5,
    parameter int         LEVEL_STEP = 5,
    parameter bit         TWINKLE_EN = 1'b1
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic [XW-1:0] pxl_x,
    input  logic [YW-1:0] y_s1,
    input  logic          advance,
    input  logic [3:0]    twinkle_phase,
    output logic          star,
    output logic [3:0]    level
);

    localparam logic [XW:0] WIDTH_W   = (XW+1)'(WIDTH);
    localparam logic [XW:0] STEP      = (XW+1)'(LAYER + 1);
    localparam logic [3:0]  LAYER_ID  = 4'(LAYER);
    localparam logic [3:0]  LEVEL     = layer_level(LAYER, BASE_LEVEL, LEVEL_STEP);
    localparam logic [3:0]  LEVEL_DIM = LEVEL >> 1;

    logic [XW-1:0] off;
    logic [XW-1:0] hx_s1;
    logic [XW:0]   off_inc;
    logic [XW:0]   off_next;
    logic [XW:0]   pix_sum;
    logic [XW:0]   pix_next;
    logic [15:0]   h;
    logic          twinkle;

    // Both sums stay below 2*WIDTH for in-range pixels, so one subtract wraps.
    assign off_inc  = {1'b0, off} + STEP;
    assign off_next = (off_inc >= WIDTH_W) ? off_inc - WIDTH_W : off_inc;
    assign pix_sum  = {1'b0, pxl_x} + {1'b0, off};
    assign pix_next = (pix_sum >= WIDTH_W) ? pix_sum - WIDTH_W : pix_sum;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            off   <= '0;
            hx_s1 <= '0;
        end else begin
            hx_s1 <= pix_next[XW-1:0];
            if (advance) off <= off_next[XW-1:0];
        end
    end

    assign h       = star_hash({{(16-XW){1'b0}}, hx_s1}, {{(16-YW){1'b0}}, y_s1}, LAYER_ID);
    assign star    = ({1'b0, h[15:8]} < DENSITY);
    assign twinkle = TWINKLE_EN && ((h & 16'h000F) == {12'd0, twinkle_phase});
    assign level   = twinkle ? LEVEL_DIM : LEVEL;

endmodule

// File: rtl/draw_starfield.sv
// Multi-layer parallax starfield background: init sequencer, frame detection,
// scroll pacing, per-layer generators, priority mux and output registers.
module draw_starfield
    import starfield_pkg::*;
#(
    parameter int         WIDTH       = 640,
    parameter int         HEIGHT      = 480,
    parameter int         NUM_LAYERS  = 3,
    parameter logic [8:0] DENSITY     = 9'd6,
    parameter int         BASE_LEVEL  = 5,
    parameter int         LEVEL_STEP  = 5,
    parameter int         SCROLL_DIV  = 4,
    parameter bit         TWINKLE_EN  = 1'b1,
    parameter int         INIT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [$clog2(WIDTH)-1:0]  pxl_x,
    input  logic [$clog2(HEIGHT)-1:0] pxl_y,
    input  logic                      enable,
    output logic [3:0]                Red,
    output logic [3:0]                Green,
    output logic [3:0]                Blue,
    output logic                      Draw,
    output logic                      frame_start
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int DW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SCROLL_DIV - 1);
    localparam logic [XW:0]   WIDTH_W   = (XW+1)'(WIDTH);
    localparam logic [YW:0]   HEIGHT_W  = (YW+1)'(HEIGHT);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] init_cnt;
    logic [CW-1:0] init_cnt_next;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
        end
    end

    // RUN is terminal; only reset brings the block back to INIT.
    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        case (state)
            INIT: begin
                init_cnt_next = init_cnt + 1'b1;
                if (init_cnt == INIT_LAST) state_next = RUN;
            end
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    logic          at_origin;
    logic          prev_origin;
    logic          frame_evt;
    logic          advance;
    logic [7:0]    frame_cnt;
    logic [DW-1:0] div_cnt;

    assign at_origin = (pxl_x == '0) && (pxl_y == '0);
    assign frame_evt = (state == RUN) && at_origin && !prev_origin;
    assign advance   = frame_evt && enable && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prev_origin <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            div_cnt     <= '0;
        end else begin
            prev_origin <= at_origin;
            frame_start <= frame_evt;
            if (frame_evt && enable) begin
                frame_cnt <= frame_cnt + 8'd1;
                div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            end
        end
    end

    // Stage 1: qualifiers travel with the pixel so Draw honours pipeline latency.
    logic [YW-1:0] y_s1;
    logic          in_range_s1;
    logic          en_s1;
    logic          run_s1;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            y_s1        <= '0;
            in_range_s1 <= 1'b0;
            en_s1       <= 1'b0;
            run_s1      <= 1'b0;
        end else begin
            y_s1        <= pxl_y;
            in_range_s1 <= ({1'b0, pxl_x} < WIDTH_W) && ({1'b0, pxl_y} < HEIGHT_W);
            en_s1       <= enable;
            run_s1      <= (state == RUN);
        end
    end

    logic [NUM_LAYERS-1:0] star;
    logic [3:0]            level [NUM_LAYERS];

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
        starfield_layer #(
            .WIDTH      (WIDTH),
            .XW         (XW),
            .YW         (YW),
            .LAYER      (i),
            .DENSITY    (DENSITY),
            .BASE_LEVEL (BASE_LEVEL),
            .LEVEL_STEP (LEVEL_STEP),
            .TWINKLE_EN (TWINKLE_EN)
        ) u_layer (
            .clk           (clk),
            .resetN        (resetN),
            .pxl_x         (pxl_x),
            .y_s1          (y_s1),
            .advance       (advance),
            .twinkle_phase (frame_cnt[5:2]),
            .star          (star[i]),
            .level         (level[i])
        );
    end

    // Nearest layer (highest index) wins.
    logic       any_star;
    logic [3:0] level_sel;
    logic       draw_next;

    always_comb begin
        any_star  = 1'b0;
        level_sel = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (star[i]) begin
                any_star  = 1'b1;
                level_sel = level[i];
            end
        end
    end

    assign draw_next = in_range_s1 && en_s1 && run_s1 && any_star;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            Draw  <= 1'b0;
            Red   <= '0;
            Green <= '0;
            Blue  <= '0;
        end else begin
            Draw  <= draw_next;
            Red   <= draw_next ? level_sel : 4'd0;
            Green <= draw_next ? level_sel : 4'd0;
            Blue  <= draw_next ? level_sel : 4'd0;
        end
    end

endmodule

// File: tb/tb_draw_starfield.sv
// Randomised bench: three differently parameterised starfields share one
// coordinate stream and are compared against a cycle-level reference model.
module tb_draw_starfield;

    localparam int ND = 3;

    logic       clk    = 1'b0;
    logic       resetN = 1'b1;
    logic [9:0] pxl_x  = '0;
    logic [8:0] pxl_y  = '0;
    logic       enable = 1'b0;

    logic [3:0] red   [ND];
    logic [3:0] green [ND];
    logic [3:0] blue  [ND];
    logic       draw  [ND];
    logic       fstart[ND];

    always #5 clk = ~clk;

    draw_starfield u_dut_a (
        .clk(clk), .resetN(resetN), .pxl_x(pxl_x), .pxl_y(pxl_y), .enable(enable),
        .Red(red[0]), .Green(green[0]), .Blue(blue[0]), .Draw(draw[0]), .frame_start(fstart[0])
    );

    draw_starfield #(
        .NUM_LAYERS(3), .DENSITY(9'd100), .BASE_LEVEL(3), .LEVEL_STEP(4),
        .SCROLL_DIV(1), .TWINKLE_EN(1'b1)
    ) u_dut_b (
        .clk(clk), .resetN(resetN), .pxl_x(pxl_x), .pxl_y(pxl_y), .enable(enable),
        .Red(red[1]), .Green(green[1]), .Blue(blue[1]), .Draw(draw[1]), .frame_start(fstart[1])
    );

    draw_starfield #(
        .NUM_LAYERS(1), .DENSITY(9'd256), .BASE_LEVEL(5), .LEVEL_STEP(5),
        .SCROLL_DIV(1), .TWINKLE_EN(1'b1)
    ) u_dut_c (
        .clk(clk), .resetN(resetN), .pxl_x(pxl_x), .pxl_y(pxl_y), .enable(enable),
        .Red(red[2]), .Green(green[2]), .Blue(blue[2]), .Draw(draw[2]), .frame_start(fstart[2])
    );

    // Reference-model parameters, one entry per instance above.
    int p_layers [ND] = '{3, 3, 1};
    int p_density[ND] = '{6, 100, 256};
    int p_base   [ND] = '{5, 3, 5};
    int p_step   [ND] = '{5, 4, 5};
    int p_div    [ND] = '{4, 1, 1};
    int p_tw     [ND] = '{1, 1, 1};

    int          off [ND][8];
    int          fcnt[ND];
    int          dcnt[ND];
    logic [12:0] e1  [ND];
    logic [12:0] e2  [ND];
    logic        f1;
    bit          prev_origin;
    int          k;

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("%s_pix_d%0d", tag, d), {draw[d], red[d], green[d], blue[d]}, 13'd0);
            check($sformatf("%s_fs_d%0d", tag, d), {12'd0, fstart[d]}, 13'd0);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 8; i++) off[d][i] = 0;
            fcnt[d] = 0;
            dcnt[d] = 0;
            e1[d]   = '0;
            e2[d]   = '0;
        end
        f1          = 1'b0;
        prev_origin = 1'b0;
        k           = 0;
    endtask

    // Expected {Draw, R, G, B} for one pixel from the placement and colour rules.
    function automatic logic [12:0] model_pix(input int d, input int x, input int y, input bit active);
        int hx, h, lvl, best;
        best = -1;
        if (!active || x >= 640 || y >= 480) return 13'd0;
        for (int i = 0; i < p_layers[d]; i++) begin
            hx = (x + off[d][i]) % 640;
            h  = ((hx * 40503) ^ (y * 32587) ^ (7483 * (i + 1))) & 32'hFFFF;
            if ((h >> 8) < p_density[d]) begin
                lvl = p_base[d] + i * p_step[d];
                if (lvl > 15) lvl = 15;
                if (p_tw[d] != 0 && (h % 16) == ((fcnt[d] / 4) % 16)) lvl = lvl / 2;
                best = lvl;
            end
        end
        if (best < 0) return 13'd0;
        return {1'b1, 4'(best), 4'(best), 4'(best)};
    endfunction

    // Called just after a falling edge: checks, drives one pixel, advances the model.
    task automatic do_cycle(input int x, input int y, input bit en);
        bit          run, origin, fs;
        logic [12:0] cur;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("pixel_d%0d_k%0d", d, k), {draw[d], red[d], green[d], blue[d]}, e2[d]);
            check($sformatf("frame_start_d%0d_k%0d", d, k), {12'd0, fstart[d]}, {12'd0, f1});
        end
        pxl_x  = 10'(x);
        pxl_y  = 9'(y);
        enable = en;
        run    = (k >= 16);
        origin = (x == 0) && (y == 0);
        fs     = run && origin && !prev_origin;
        prev_origin = origin;
        for (int d = 0; d < ND; d++) begin
            if (fs && en) fcnt[d] = (fcnt[d] + 1) % 256;
            cur   = model_pix(d, x, y, en && run);
            e2[d] = e1[d];
            e1[d] = cur;
            if (fs && en) begin
                dcnt[d]++;
                if (dcnt[d] == p_div[d]) begin
                    dcnt[d] = 0;
                    for (int i = 0; i < 8; i++) off[d][i] = (off[d][i] + i + 1) % 640;
                end
            end
        end
        f1 = fs;
        k++;
    endtask

    task automatic step(input int x, input int y, input bit en);
        @(negedge clk);
        do_cycle(x, y, en);
    endtask

    function automatic bit pick_en(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ($urandom_range(0, 7) != 0);
    endfunction

    // Short synthetic frame: origin (sometimes repeated), a run across a random
    // or right-edge column span, then scattered pixels including blanking.
    task automatic frame(input int mode);
        int x0, y0;
        step(0, 0, pick_en(mode));
        if ($urandom_range(0, 3) == 0) step(0, 0, pick_en(mode));
        x0 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(620, 640)) : int'($urandom_range(0, 600));
        y0 = int'($urandom_range(0, 490));
        for (int i = 0; i < 12; i++) step(x0 + i, y0, pick_en(mode));
        for (int i = 0; i < 8; i++) step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)), pick_en(mode));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        pxl_x    = '0;
        pxl_y    = '0;
        enable   = 1'b1;
        #2 resetN = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");

        @(negedge clk);
        resetN = 1'b1;
        do_cycle(5, 7, 1'b1);
        repeat (30) step(int'($urandom_range(1, 639)), int'($urandom_range(0, 479)), 1'b1);

        repeat (350) frame(1);
        repeat (3) frame(0);
        repeat (350) frame(2);

        // Asynchronous reset in the middle of a line.
        repeat (5) step(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1);
        @(posedge clk);
        #2 resetN = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("held_reset");
        @(negedge clk);
        resetN = 1'b1;
        do_cycle(9, 3, 1'b1);
        repeat (30) step(int'($urandom_range(1, 639)), int'($urandom_range(0, 479)), 1'b1);
        repeat (20) frame(1);
        repeat (3) step(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
